aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Upstream sequencer and round-key store for aes_key_gen. It accepts a 128-bit cipher key over a valid/ready handshake and drives aes_key_gen one round at a time, feeding each generated key back as the next pre_rnd_key. It captures all 11 AES-128 round keys into an internal register file. The cipher datapath reads round keys by index, and can start as soon as the rounds it needs are available.

Parameters:
KEYGEN_LAT, 1, cycles from o_en_key_gen asserted to i_next_rnd_key valid (1..4)
NUM_RND, 10, number of expansion rounds; slots held = NUM_RND+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_key  input  128  cipher key (round-0 key)
i_key_valid  input  1  i_key is valid
o_key_ready  output  1  controller can accept a key
o_en_key_gen  output  1  enable to aes_key_gen
o_round_num  output  4  round number to aes_key_gen
o_pre_rnd_key  output  128  previous round key to aes_key_gen
i_next_rnd_key  input  128  round key from aes_key_gen
i_rd_en  input  1  round-key read request
i_rd_idx  input  4  round index to read (0..10)
o_rd_key  output  128  registered read data
o_rd_valid  output  1  o_rd_key valid, one-cycle pulse
o_rnd_avail  output  4  number of slots written (0..11)
o_keys_done  output  1  all 11 round keys stored

Behaviour:
- Reset (async assert, sync deassert expected):
  - state=IDLE; all slots=0; o_rnd_avail=0; o_keys_done=0; o_rd_valid=0; o_rd_key=0.
  - o_en_key_gen=0; o_round_num=0; o_pre_rnd_key=0.
  - o_key_ready=1 from the first cycle after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- o_key_ready=1 in IDLE and DONE only.
- Accept: i_key_valid&&o_key_ready at edge E0:
  - slot0<=i_key; o_rnd_avail<=1; o_keys_done<=0; r<=1; ->ISSUE.
- ISSUE (exactly one cycle):
  - o_en_key_gen=1; o_round_num=r; o_pre_rnd_key=slot[r-1].
  - Outputs are registered and valid throughout the ISSUE cycle; then ->WAIT.
- WAIT:
  - o_en_key_gen=0; o_round_num and o_pre_rnd_key hold their values.
  - A counter waits KEYGEN_LAT cycles.
  - On the final WAIT edge: slot[r]<=i_next_rnd_key; o_rnd_avail<=r+1.
  - If r==NUM_RND: o_keys_done<=1, ->DONE. Else r<=r+1, ->ISSUE.
- Timing with KEYGEN_LAT=1:
  - Slot r is written at edge E0+2r.
  - o_keys_done rises at E0+20.
  - Per round: 1+KEYGEN_LAT cycles.
- DONE: o_key_ready=1. A new accepted key restarts exactly as from IDLE; slots 1..10 keep stale data but are not readable until rewritten.
- i_key_valid while busy (ISSUE/WAIT): ignored, not accepted; the source must hold its key.
- Read:
  - i_rd_en at edge with i_rd_idx < o_rnd_avail (value before the edge): o_rd_key<=slot[i_rd_idx]; o_rd_valid<=1 the next cycle.
  - Index >= o_rnd_avail or >10: o_rd_valid<=0; o_rd_key holds.
  - Read of a slot written on the same edge is refused.
- Reads are allowed in every state and never stall expansion.
- o_rnd_avail is monotonic within one expansion and returns to 1 on a new accept.
- Reset mid-expansion: immediate return to reset values; any in-flight aes_key_gen result is discarded.
- Widths: r is 4-bit; o_rnd_avail saturates at NUM_RND+1.

Test Plan:
- Reset -> o_key_ready=1, o_rnd_avail=0, o_keys_done=0, o_en_key_gen=0, o_rd_valid=0.
- Key 2b7e151628aed2a6abf7158809cf4f3c accepted at E0, real aes_key_gen attached:
  - o_en_key_gen pulses 10 times, round_num 1..10, each 2 cycles apart.
  - o_keys_done=1 at E0+20.
  - Read idx1 -> a0fafe1788542cb123a339392a6c7605.
  - Read idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Early read:
  - Read idx3 at E0+5 (avail=3) -> o_rd_valid=0.
  - Read idx3 at E0+7 -> o_rd_valid=1 with the round-3 key.
- i_key_valid held with a different key during expansion -> not accepted; accepted in DONE, avail drops to 1, read idx0 returns the new key.
- rst_n low at E0+9 -> all outputs at reset values asynchronously; a fresh key afterward expands correctly to completion.
- KEYGEN_LAT=3 with a delay-model key gen -> 4 cycles per round; o_keys_done at E0+40; all keys match FIPS-197.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences aes_key_gen one round at a time and stores all round keys.
module aes_key_sched_ctrl #(
   parameter int KEYGEN_LAT = 1,
   parameter int NUM_RND    = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] i_key,
   input  logic         i_key_valid,
   output logic         o_key_ready,
   output logic         o_en_key_gen,
   output logic [3:0]   o_round_num,
   output logic [127:0] o_pre_rnd_key,
   input  logic [127:0] i_next_rnd_key,
   input  logic         i_rd_en,
   input  logic [3:0]   i_rd_idx,
   output logic [127:0] o_rd_key,
   output logic         o_rd_valid,
   output logic [3:0]   o_rnd_avail,
   output logic         o_keys_done
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic [1:0] LAT_M1 = 2'(KEYGEN_LAT - 1);
   state_t         r_state, w_next;
   logic [3:0]     r_rnd, r_avail;
   logic [1:0]     r_cnt;
   logic           r_en, r_done, r_rd_valid;
   logic [127:0]   r_pre, r_rd_key;
   logic [127:0]   r_slot [0:NUM_RND];
   logic           w_accept, w_last_wait, w_final, w_rd_ok;
   assign o_key_ready   = (r_state == IDLE) || (r_state == DONE);
   assign w_accept      = i_key_valid && o_key_ready;
   assign w_last_wait   = (r_state == WAIT) && (r_cnt == LAT_M1);
   assign w_final       = r_rnd == 4'(NUM_RND);
   // r_avail never exceeds NUM_RND+1, so this also refuses indices beyond the store
   assign w_rd_ok       = i_rd_en && (i_rd_idx < r_avail);
   assign o_en_key_gen  = r_en;
   assign o_round_num   = r_rnd;
   assign o_pre_rnd_key = r_pre;
   assign o_rd_key      = r_rd_key;
   assign o_rd_valid    = r_rd_valid;
   assign o_rnd_avail   = r_avail;
   assign o_keys_done   = r_done;
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = ISSUE;
      else if (r_state == ISSUE) w_next = WAIT;
      else if (w_last_wait) w_next = w_final ? DONE : ISSUE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NUM_RND; i++) r_slot[i] <= '0;
         r_rnd      <= '0;
         r_avail    <= '0;
         r_cnt      <= '0;
         r_en       <= 1'b0;
         r_done     <= 1'b0;
         r_pre      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_key   <= '0;
      end else begin
         if (w_accept) begin
            r_slot[0] <= i_key;
            r_avail   <= 4'd1;
            r_done    <= 1'b0;
            r_rnd     <= 4'd1;
            r_en      <= 1'b1;
            r_pre     <= i_key;
         end else if (r_state == ISSUE) begin
            r_en  <= 1'b0;
            r_cnt <= '0;
         end else if (w_last_wait) begin
            r_slot[r_rnd] <= i_next_rnd_key;
            r_avail       <= r_rnd + 4'd1;
            if (w_final) r_done <= 1'b1;
            else begin
               // the freshly generated key is the seed for the next round
               r_rnd <= r_rnd + 4'd1;
               r_en  <= 1'b1;
               r_pre <= i_next_rnd_key;
            end
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 2'd1;
         end
         r_rd_valid <= w_rd_ok;
         if (w_rd_ok) r_rd_key <= r_slot[i_rd_idx];
      end
   end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench with FIPS-197 key models at latency 1 and 3.
module tb_aes_key_sched_ctrl;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, failures = 0, c0 = 0, base1 = 0, base3 = 0;
   localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;

   function automatic logic [127:0] fk(input int i);
      case (i)
         0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
         1:  return 128'ha0fafe1788542cb123a339392a6c7605;
         2:  return 128'hf2c295f27a96b9435935807a7359f67f;
         3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
         4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
         5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
         6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
         7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
         8:  return 128'head27321b58dbad2312bf5607f8d292f;
         9:  return 128'hac7766f319fadc2128d12941575c006e;
         10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
         default: return '0;
      endcase
   endfunction

   // key gen model: correct next key only when fed the correct previous key
   function automatic logic [127:0] f(input logic [3:0] r, input logic [127:0] p);
      return (p == fk(int'(r) - 1)) ? fk(int'(r)) : p ^ {32{r}};
   endfunction

   logic [127:0] k1 = '0, pre1, nxt1 = '0, rdk1;
   logic         kv1 = 0, kr1, en1, rde1 = 0, rdv1, dn1;
   logic [3:0]   rn1, rdi1 = '0, av1;
   logic [127:0] k3 = '0, pre3, nxt3 = '0, rdk3, pend3 = '0;
   logic         kv3 = 0, kr3, en3, rde3 = 0, rdv3, dn3;
   logic [3:0]   rn3, rdi3 = '0, av3;
   int           kc3 = 0;

   aes_key_sched_ctrl #(.KEYGEN_LAT(1), .NUM_RND(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_key(k1), .i_key_valid(kv1), .o_key_ready(kr1),
      .o_en_key_gen(en1), .o_round_num(rn1), .o_pre_rnd_key(pre1), .i_next_rnd_key(nxt1),
      .i_rd_en(rde1), .i_rd_idx(rdi1), .o_rd_key(rdk1), .o_rd_valid(rdv1),
      .o_rnd_avail(av1), .o_keys_done(dn1));

   aes_key_sched_ctrl #(.KEYGEN_LAT(3), .NUM_RND(10)) dut3 (
      .clk(clk), .rst_n(rst_n), .i_key(k3), .i_key_valid(kv3), .o_key_ready(kr3),
      .o_en_key_gen(en3), .o_round_num(rn3), .o_pre_rnd_key(pre3), .i_next_rnd_key(nxt3),
      .i_rd_en(rde3), .i_rd_idx(rdi3), .o_rd_key(rdk3), .o_rd_valid(rdv3),
      .o_rnd_avail(av3), .o_keys_done(dn3));

   always @(posedge clk) if (en1) nxt1 <= f(rn1, pre1);
   always @(posedge clk) begin
      if (en3) begin
         pend3 <= f(rn3, pre3);
         kc3   <= 2;
      end else if (kc3 != 0) begin
         kc3 <= kc3 - 1;
         if (kc3 == 1) nxt3 <= pend3;
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic go_to(input int k);
      repeat (c0 + k - cyc) @(negedge clk);
   endtask

   logic [127:0] q1[$], q3[$];
   int l1r[$], l1c[$], l3r[$], l3c[$];
   always @(negedge clk) begin
      if (rdv1) begin
         if (q1.size() == 0) chk("rd1_unexpected_valid", 128'(rdv1), 128'd0);
         else chk("rd1_key", rdk1, q1.pop_front());
      end
      if (rdv3) begin
         if (q3.size() == 0) chk("rd3_unexpected_valid", 128'(rdv3), 128'd0);
         else chk("rd3_key", rdk3, q3.pop_front());
      end
      if (en1) begin l1r.push_back(int'(rn1)); l1c.push_back(cyc); end
      if (en3) begin l3r.push_back(int'(rn3)); l3c.push_back(cyc); end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_ready", 128'(kr1), 128'd1);
      chk("rst_avail", 128'(av1), 128'd0);
      chk("rst_done", 128'(dn1), 128'd0);
      chk("rst_en", 128'(en1), 128'd0);
      chk("rst_rd_valid", 128'(rdv1), 128'd0);
      chk("rst_rd_key", rdk1, 128'd0);
      chk("rst_round", 128'(rn1), 128'd0);
      chk("rst_pre", pre1, 128'd0);
      // expansion at latency 1
      base1 = l1r.size();
      k1 = K; kv1 = 1;
      @(negedge clk); c0 = cyc; kv1 = 0;
      chk("acc_avail", 128'(av1), 128'd1);
      chk("acc_en", 128'(en1), 128'd1);
      chk("acc_round", 128'(rn1), 128'd1);
      chk("acc_pre", pre1, K);
      chk("acc_busy", 128'(kr1), 128'd0);
      go_to(4); rde1 = 1; rdi1 = 3;
      go_to(5); chk("early_rd_refused", 128'(rdv1), 128'd0);
      go_to(6); chk("same_edge_rd_refused", 128'(rdv1), 128'd0); q1.push_back(fk(3));
      go_to(7); rde1 = 0; k1 = K2; kv1 = 1;
      go_to(8); chk("mid_avail", 128'(av1), 128'd5); chk("mid_busy", 128'(kr1), 128'd0);
      go_to(19); chk("done_early", 128'(dn1), 128'd0);
      rde1 = 1; rdi1 = 1; q1.push_back(fk(1));
      go_to(20); chk("done", 128'(dn1), 128'd1); chk("done_avail", 128'(av1), 128'd11);
      chk("done_ready", 128'(kr1), 128'd1);
      rdi1 = 10; q1.push_back(fk(10));
      go_to(21); chk("reacc_avail", 128'(av1), 128'd1); chk("reacc_done", 128'(dn1), 128'd0);
      kv1 = 0; rdi1 = 0; q1.push_back(K2);
      go_to(22); rde1 = 0;
      for (int i = 0; i < 10; i++) begin
         chk("en1_round", 128'(l1r[base1 + i]), 128'(i + 1));
         chk("en1_cycle", 128'(l1c[base1 + i]), 128'(c0 + 2 * i));
      end
      go_to(41); chk("k2_done", 128'(dn1), 128'd1);
      // reset in the middle of an expansion
      k1 = K; kv1 = 1;
      @(negedge clk); c0 = cyc; kv1 = 0;
      go_to(8); rst_n = 0; #1;
      chk("arst_avail", 128'(av1), 128'd0);
      chk("arst_en", 128'(en1), 128'd0);
      chk("arst_round", 128'(rn1), 128'd0);
      chk("arst_pre", pre1, 128'd0);
      chk("arst_done", 128'(dn1), 128'd0);
      chk("arst_rd_key", rdk1, 128'd0);
      @(negedge clk); @(negedge clk); rst_n = 1;
      @(negedge clk); chk("post_rst_ready", 128'(kr1), 128'd1);
      k1 = K; kv1 = 1;
      @(negedge clk); c0 = cyc; kv1 = 0;
      go_to(19); rde1 = 1; rdi1 = 5; q1.push_back(fk(5));
      go_to(20); chk("post_rst_done", 128'(dn1), 128'd1); rdi1 = 10; q1.push_back(fk(10));
      go_to(21); rde1 = 0;
      // latency 3
      base3 = l3r.size();
      k3 = K; kv3 = 1;
      @(negedge clk); c0 = cyc; kv3 = 0;
      go_to(39); chk("lat3_done_early", 128'(dn3), 128'd0);
      go_to(40); chk("lat3_done", 128'(dn3), 128'd1); chk("lat3_avail", 128'(av3), 128'd11);
      chk("lat3_ready", 128'(kr3), 128'd1);
      for (int i = 0; i <= 10; i++) begin
         rde3 = 1; rdi3 = 4'(i); q3.push_back(fk(i));
         @(negedge clk);
      end
      rde3 = 0;
      for (int i = 0; i < 10; i++) begin
         chk("en3_round", 128'(l3r[base3 + i]), 128'(i + 1));
         chk("en3_cycle", 128'(l3c[base3 + i]), 128'(c0 + 4 * i));
      end
      repeat (3) @(negedge clk);
      chk("q1_drained", 128'(q1.size()), 128'd0);
      chk("q3_drained", 128'(q3.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
